// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an external PWM waveform. It reports the period (rising edge to
// rising edge) and the high time, both counted in prescaled clock ticks.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active-low
//   pwm_in     PWM input, asynchronous to clk
//   scale      prescale; one tick every scale+1 clocks
//   period     last measured period, in ticks
//   high_time  last measured high time, in ticks
//   valid      one-clock strobe; period/high_time updated this cycle
//   timeout    period counter saturated without a rising edge; held until
//              the next valid
//
// Optional feature (macro PWMCAP_FILTER_EN):
//   When defined, the synchronised input must hold a new level for
//   FILT_DEPTH consecutive clocks before the internal level follows it.
//   When undefined, there is no filter logic.
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_WIDTH  = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int FILT_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  input  logic [DIV_WIDTH-1:0] scale,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 timeout
);

  if (FILT_DEPTH < 1) begin : g_filt_depth_check
    $error("pwm_capture: FILT_DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {
    SEEK,
    HIGH,
    LOW
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchroniser, optional glitch filter, edge detect
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic s;
  logic s_prev;
  logic rise;
  logic fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWMCAP_FILTER_EN
  localparam int FW = $clog2(FILT_DEPTH + 1);

  logic [FW-1:0] filt_cnt;
  logic          s_filt;

  // filt_cnt counts consecutive clocks on which sync2 disagrees with the
  // filtered level; the level flips on the FILT_DEPTH-th such clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_cnt <= '0;
      s_filt   <= 1'b0;
    end else if (sync2 == s_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_DEPTH - 1)) begin
      filt_cnt <= '0;
      s_filt   <= sync2;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign s = s_filt;
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;

  // ---------------------------------------------------------------------------
  // Prescaler: down-counter, tick at zero. A rise reloads it so ticks are
  // phase-aligned to the start of each period.
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] presc;
  logic                 tick;

  assign tick = (presc == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (rise || tick) begin
      presc <= scale;
    end else begin
      presc <= presc - DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement state machine
  // ---------------------------------------------------------------------------
  state_t               state,     state_nxt;
  logic [CNT_WIDTH-1:0] pcnt,      pcnt_nxt;
  logic [CNT_WIDTH-1:0] hcnt,      hcnt_nxt;
  logic [CNT_WIDTH-1:0] hold,      hold_nxt;
  logic [CNT_WIDTH-1:0] period_nxt;
  logic [CNT_WIDTH-1:0] high_nxt;
  logic                 valid_nxt;
  logic                 timeout_nxt;
  logic                 sat;

  assign sat = &pcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEEK;
      pcnt      <= '0;
      hcnt      <= '0;
      hold      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      hcnt      <= hcnt_nxt;
      hold      <= hold_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pcnt_nxt    = pcnt;
    hcnt_nxt    = hcnt;
    hold_nxt    = hold;
    period_nxt  = period;
    high_nxt    = high_time;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout;

    unique case (state)
      SEEK: begin
        if (rise) begin
          pcnt_nxt  = CNT_WIDTH'(1);
          hcnt_nxt  = CNT_WIDTH'(1);
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        if (tick && sat) begin
          timeout_nxt = 1'b1;
          state_nxt   = SEEK;
        end else begin
          // The fall cycle still belongs to the period, so its tick counts
          // toward the period but not toward the high time.
          if (tick) begin
            pcnt_nxt = pcnt + CNT_WIDTH'(1);
          end
          if (fall) begin
            hold_nxt  = hcnt;
            state_nxt = LOW;
          end else if (tick) begin
            hcnt_nxt = hcnt + CNT_WIDTH'(1);
          end
        end
      end

      LOW: begin
        if (rise) begin
          period_nxt  = pcnt;
          high_nxt    = hold;
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          pcnt_nxt    = CNT_WIDTH'(1);
          hcnt_nxt    = CNT_WIDTH'(1);
          state_nxt   = HIGH;
        end else if (tick && sat) begin
          timeout_nxt = 1'b1;
          state_nxt   = SEEK;
        end else if (tick) begin
          pcnt_nxt = pcnt + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_nxt = SEEK;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int DW   = 8;
  localparam int FD   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          pwm_in;
  logic [DW-1:0] scale;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;

  pwm_capture #(
    .CNT_WIDTH (CW),
    .DIV_WIDTH (DW),
    .FILT_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pwm_in   (pwm_in),
    .scale    (scale),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on pin edge times (in clocks). A period from rise
  // r0 to rise r1 spans P = r1-r0 clocks; ticks fall every scale+1 clocks
  // after r0 and the rise cycle itself is not counted, so the count is
  // 1 + floor((P-1)/(scale+1)). High time uses the fall instead of r1.
  // A count above the counter maximum means a timeout instead of a result.
  // ---------------------------------------------------------------------------
  typedef struct {
    int p;
    int h;
    int rc;
  } exp_t;

  exp_t q[$];
  bit   have_rise = 1'b0;
  int   last_rise = 0;
  int   last_fall = 0;
  int   last_p    = 0;
  int   last_h    = 0;

  task automatic model_rise(input int c);
    int   div;
    int   p;
    int   h;
    exp_t e;
    div = int'(scale) + 1;
    if (have_rise) begin
      p = 1 + (c - last_rise - 1) / div;
      h = 1 + (last_fall - last_rise - 1) / div;
      if (p <= MAXC) begin
        e.p = p;
        e.h = h;
        e.rc = c;
        q.push_back(e);
        last_p = p;
        last_h = h;
      end
    end
    last_rise = c;
    have_rise = 1'b1;
  endtask

  task automatic model_fall(input int c);
    last_fall = c;
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    if (v && !pwm_in) model_rise(cyc);
    else if (!v && pwm_in) model_fall(cyc);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic do_reset(input logic [DW-1:0] sc);
    chk("queue_drained", q.size(), 0);
    reset  = 1'b0;
    pwm_in = 1'b0;
    scale  = sc;
    have_rise = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 5);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per valid strobe
  // ---------------------------------------------------------------------------
  int lat_ref = -1;

  initial begin
    bit   prev_valid;
    exp_t e;
    int   lat;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && valid) begin
        chk("valid_not_back_to_back", int'(prev_valid), 0);
        if (q.size() == 0) begin
          chk("unexpected_valid_period", int'(period), -1);
        end else begin
          e = q.pop_front();
          chk("period", int'(period), e.p);
          chk("high_time", int'(high_time), e.h);
          chk("timeout_at_valid", int'(timeout), 0);
          lat = cyc - e.rc;
          if (lat_ref < 0) lat_ref = lat;
          else chk("valid_latency", lat, lat_ref);
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n2;
    int tcyc;
    reset  = 1'b0;
    pwm_in = 1'b0;
    scale  = '0;
    #3;
    chk("reset_period", int'(period), 0);
    chk("reset_high_time", int'(high_time), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_timeout", int'(timeout), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 5);

    // Basic: 100/25 at scale 0
    for (int i = 0; i < 6; i++) wave(25, 75);
    chk("basic_timeout_low", int'(timeout), 0);

    // Prescale: 200/60 at scale 3
    do_reset(8'd3);
    for (int i = 0; i < 5; i++) wave(60, 140);

    // Randomised waveforms and prescale
    do_reset(DW'($urandom_range(0, 3)));
    for (int i = 0; i < 12; i++) wave($urandom_range(3, 40), $urandom_range(3, 60));
    do_reset(DW'($urandom_range(4, 7)));
    for (int i = 0; i < 8; i++) wave($urandom_range(3, 80), $urandom_range(3, 120));

    // Timeout: one rise then held low
    do_reset(8'd0);
    wave(25, 75);
    wave(25, 75);
    n2 = cyc;
    drive(1'b1, 10);
    drive(1'b0, 1);
    tcyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (timeout) begin
        tcyc = cyc;
        break;
      end
    end
    chk("timeout_delay", tcyc - n2, lat_ref + 255);
    @(posedge clk);
    #1;
    chk("timeout_hold_period", int'(period), last_p);
    chk("timeout_hold_high", int'(high_time), last_h);
    drive(1'b1, 10);
    chk("timeout_sticky", int'(timeout), 1);
    drive(1'b1, 15);
    drive(1'b0, 75);
    chk("timeout_sticky_first_rise", int'(timeout), 1);
    wave(25, 75);
    wave(25, 75);
    chk("timeout_cleared", int'(timeout), 0);

`ifndef PWMCAP_FILTER_EN
    // Minimum waveform: period 2, high 1
    do_reset(8'd0);
    for (int i = 0; i < 20; i++) wave(1, 1);
    drive(1'b0, 10);
`endif

    // Reset in the middle of a high phase
    do_reset(8'd0);
    wave(25, 75);
    wave(25, 75);
    drive(1'b1, 10);
    chk("pre_reset_queue", q.size(), 0);
    reset = 1'b0;
    #1;
    chk("midreset_period", int'(period), 0);
    chk("midreset_high_time", int'(high_time), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_timeout", int'(timeout), 0);
    have_rise = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    // Synchroniser restarts at 0 while the pin is high: seen as a rise now.
    if (pwm_in) model_rise(cyc);
    drive(1'b1, 15);
    drive(1'b0, 75);
    for (int i = 0; i < 3; i++) wave(25, 75);

    // Glitch in the low phase
    do_reset(8'd0);
    wave(25, 75);
    drive(1'b1, 25);
    drive(1'b0, 40);
`ifdef PWMCAP_FILTER_EN
    pwm_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    repeat (33) @(posedge clk);
    #1;
`else
    drive(1'b1, 2);
    drive(1'b0, 33);
`endif
    wave(25, 75);
    wave(25, 75);

    drive(1'b0, 20);
    chk("final_queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
